bids_round_sequencer: RTL

Host-side sequencer for the BIDS22 auction controller. It accepts one "run round" request, with balances, mask, timer, bid charge, key and round length, over a valid/ready handshake. It then drives the controller's C_op/C_data/C_start port through the full unlock → configure → lock → round sequence, and returns winner, maxBid and error status as a one-cycle result pulse. It sits between the system host and the controller's C_* port; bidder ports are untouched.

---
 rtl/bids_pkg.sv | 46 ++++
 rtl/bids_round_sequencer_if.sv | 39 +++
 rtl/bids_seq_counter.sv | 32 +++
 rtl/bids_round_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bids_pkg.sv
// Shared definitions for the BIDS22 host-side round sequencer.
// Contents:
//   - controller opcodes (NoOperation .. BidCharge)
//   - controller error codes and the two sequencer-only codes
//   - the sequencer state enum
package bids_pkg;

  // Controller opcodes driven on C_op
  localparam logic [3:0] OP_NO_OPERATION = 4'd0;
  localparam logic [3:0] OP_UNLOCK       = 4'd1;
  localparam logic [3:0] OP_LOCK         = 4'd2;
  localparam logic [3:0] OP_LOAD_X       = 4'd3;
  localparam logic [3:0] OP_LOAD_Y       = 4'd4;
  localparam logic [3:0] OP_LOAD_Z       = 4'd5;
  localparam logic [3:0] OP_MASK         = 4'd6;
  localparam logic [3:0] OP_TIMER        = 4'd7;
  localparam logic [3:0] OP_BID_CHARGE   = 4'd8;

  // Controller error codes reported on ctl_err
  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_BAD_KEY  = 3'b001;
  localparam logic [2:0] ERR_LOCKOUT  = 3'b010;
  localparam logic [2:0] ERR_BAD_OP   = 3'b011;
  localparam logic [2:0] ERR_FUNDS    = 3'b100;
  localparam logic [2:0] ERR_TIE      = 3'b101;

  // Codes only the sequencer produces
  localparam logic [2:0] SEQ_ERR_OP      = 3'b110;
  localparam logic [2:0] SEQ_ERR_TIMEOUT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_UNLOCK,
    S_LOADX,
    S_LOADY,
    S_LOADZ,
    S_MASK,
    S_TIMER,
    S_COST,
    S_LOCK,
    S_START,
    S_WAIT,
    S_CAPTURE
  } seq_state_t;

endpackage

// File: rtl/bids_round_sequencer_if.sv
// Host-side request/result bundle of the round sequencer.
// Signals:
//   req_valid/req_ready   request handshake
//   cfg_*                 round configuration carried with the request
//   res_valid/res_*       one-cycle result pulse
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the host keeps req_valid and cfg_* stable until
// then. res_valid is a single-cycle pulse with no back-pressure.
// Modports: master = host, slave = sequencer.
interface bids_round_sequencer_if #(
  parameter int ROUND_W = 16
);
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        cfg_x_bal;
  logic [31:0]        cfg_y_bal;
  logic [31:0]        cfg_z_bal;
  logic [2:0]         cfg_mask;
  logic [31:0]        cfg_timer;
  logic [31:0]        cfg_cost;
  logic [31:0]        cfg_key;
  logic [ROUND_W-1:0] cfg_round_len;
  logic               res_valid;
  logic [2:0]         res_win;
  logic [31:0]        res_maxbid;
  logic [2:0]         res_err;

  modport master (
    output req_valid, cfg_x_bal, cfg_y_bal, cfg_z_bal, cfg_mask,
           cfg_timer, cfg_cost, cfg_key, cfg_round_len,
    input  req_ready, res_valid, res_win, res_maxbid, res_err
  );

  modport slave (
    input  req_valid, cfg_x_bal, cfg_y_bal, cfg_z_bal, cfg_mask,
           cfg_timer, cfg_cost, cfg_key, cfg_round_len,
    output req_ready, res_valid, res_win, res_maxbid, res_err
  );
endinterface

// File: rtl/bids_seq_counter.sv
// Loadable down-counter used by the sequencer for the round length and,
// afterwards, for the roundOver watchdog.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   load          load load_val (has priority over dec)
//   load_val      value to load
//   dec           decrement by one, holds at zero
//   zero          count is zero
module bids_seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/bids_round_sequencer.sv
// Host-side sequencer for the BIDS22 auction controller. Takes one
// "run round" request and walks the controller through
// unlock -> load balances/mask/timer/cost -> lock -> round, then returns
// winner, maxBid and error status as a one-cycle result pulse.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   host             request/result bundle (slave modport)
//   C_op/C_data/C_start               controller command port
//   ctl_err/ctl_roundOver/ctl_maxBid/ctl_win  controller status
//   state_dbg, locked_dbg             FSM state and lock flag for observation
// Build option: define BIDS_SEQ_WATCHDOG_EN to give up on a round after
// TIMEOUT_CYC WAIT cycles without roundOver (result code 111).
module bids_round_sequencer
  import bids_pkg::*;
#(
  parameter int ROUND_W     = 16,
  parameter int TIMEOUT_CYC = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  bids_round_sequencer_if.slave        host,
  output logic [3:0]                   C_op,
  output logic [31:0]                  C_data,
  output logic                         C_start,
  input  logic [2:0]                   ctl_err,
  input  logic                         ctl_roundOver,
  input  logic [31:0]                  ctl_maxBid,
  input  logic [2:0]                   ctl_win,
  output seq_state_t                   state_dbg,
  output logic                         locked_dbg
);
  seq_state_t state_q, state_d;

  // Registered request
  logic [31:0]        x_bal_q, y_bal_q, z_bal_q, timer_q, cost_q, cfg_key_q;
  logic [2:0]         mask_q;
  logic [ROUND_W-1:0] round_len_q;

  // Key currently programmed into the controller, and whether it is locked
  logic [31:0] key_q;
  logic        locked_q;

  // Abort bookkeeping: CAPTURE reports abort_err_q instead of controller data
  logic        abort_q;
  logic [2:0]  abort_err_q;

  logic        res_valid_q;
  logic [2:0]  res_win_q, res_err_q;
  logic [31:0] res_maxbid_q;

  logic               req_ready_int, accept, do_lock, abort_set;
  logic [2:0]         abort_code;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [ROUND_W-1:0] cnt_load_val;

  // Not ready while the result pulse is out, so req_ready trails res_valid.
  assign req_ready_int = reset_n && (state_q == S_IDLE) && !res_valid_q;

  bids_seq_counter #(.W(ROUND_W)) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    C_op         = OP_NO_OPERATION;
    C_data       = '0;
    C_start      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    abort_set    = 1'b0;
    abort_code   = ERR_NONE;
    do_lock      = 1'b0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host.req_valid && req_ready_int) begin
          accept  = 1'b1;
          state_d = locked_q ? S_UNLOCK : S_LOADX;
        end
      end
      S_UNLOCK: begin
        C_op   = OP_UNLOCK;
        C_data = key_q;
        if (ctl_err == ERR_BAD_KEY) begin
          state_d    = S_CAPTURE;
          abort_set  = 1'b1;
          abort_code = ERR_BAD_KEY;
        end else begin
          state_d = S_LOADX;
        end
      end
      S_LOADX: begin C_op = OP_LOAD_X;     C_data = x_bal_q;         state_d = S_LOADY; end
      S_LOADY: begin C_op = OP_LOAD_Y;     C_data = y_bal_q;         state_d = S_LOADZ; end
      S_LOADZ: begin C_op = OP_LOAD_Z;     C_data = z_bal_q;         state_d = S_MASK;  end
      S_MASK:  begin C_op = OP_MASK;       C_data = {29'b0, mask_q}; state_d = S_TIMER; end
      S_TIMER: begin C_op = OP_TIMER;      C_data = timer_q;         state_d = S_COST;  end
      S_COST:  begin C_op = OP_BID_CHARGE; C_data = cost_q;          state_d = S_LOCK;  end
      S_LOCK: begin
        C_op     = OP_LOCK;
        C_data   = cfg_key_q;
        do_lock  = 1'b1;
        cnt_load = 1'b1;
        // Counter exits START on zero, so load len-1; length 0 runs as 1.
        cnt_load_val = (round_len_q == '0) ? '0 : round_len_q - ROUND_W'(1);
        state_d  = S_START;
      end
      S_START: begin
        C_op    = OP_LOCK;
        C_data  = key_q;
        C_start = 1'b1;
        if (cnt_zero) begin
          state_d      = S_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = ROUND_W'(TIMEOUT_CYC - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_WAIT: begin
        C_op   = OP_LOCK;
        C_data = key_q;
        if (ctl_roundOver) begin
          state_d = S_CAPTURE;
        end
`ifdef BIDS_SEQ_WATCHDOG_EN
        else if (cnt_zero) begin
          state_d    = S_CAPTURE;
          abort_set  = 1'b1;
          abort_code = SEQ_ERR_TIMEOUT;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      S_CAPTURE: begin
        // Lock with the current key returns the controller to Locked.
        C_op    = OP_LOCK;
        C_data  = key_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any controller error on a configuration op abandons the round.
    if ((state_q inside {S_LOADX, S_LOADY, S_LOADZ, S_MASK, S_TIMER, S_COST}) &&
        (ctl_err != ERR_NONE)) begin
      state_d    = S_CAPTURE;
      abort_set  = 1'b1;
      abort_code = SEQ_ERR_OP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      x_bal_q      <= '0;
      y_bal_q      <= '0;
      z_bal_q      <= '0;
      mask_q       <= '0;
      timer_q      <= '0;
      cost_q       <= '0;
      cfg_key_q    <= '0;
      round_len_q  <= '0;
      key_q        <= '0;
      locked_q     <= 1'b0;
      abort_q      <= 1'b0;
      abort_err_q  <= ERR_NONE;
      res_valid_q  <= 1'b0;
      res_win_q    <= '0;
      res_maxbid_q <= '0;
      res_err_q    <= ERR_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_bal_q     <= host.cfg_x_bal;
        y_bal_q     <= host.cfg_y_bal;
        z_bal_q     <= host.cfg_z_bal;
        mask_q      <= host.cfg_mask;
        timer_q     <= host.cfg_timer;
        cost_q      <= host.cfg_cost;
        cfg_key_q   <= host.cfg_key;
        round_len_q <= host.cfg_round_len;
        abort_q     <= 1'b0;
        abort_err_q <= ERR_NONE;
      end
      if (abort_set) begin
        abort_q     <= 1'b1;
        abort_err_q <= abort_code;
      end
      if (do_lock) begin
        key_q    <= cfg_key_q;
        locked_q <= 1'b1;
      end
      res_valid_q <= (state_q == S_CAPTURE);
      if (state_q == S_CAPTURE) begin
        if (abort_q) begin
          res_win_q    <= '0;
          res_maxbid_q <= '0;
          res_err_q    <= abort_err_q;
        end else begin
          res_win_q    <= ctl_win;
          res_maxbid_q <= ctl_maxBid;
          res_err_q    <= ctl_err;
        end
      end
    end
  end

  assign host.req_ready  = req_ready_int;
  assign host.res_valid  = res_valid_q;
  assign host.res_win    = res_win_q;
  assign host.res_maxbid = res_maxbid_q;
  assign host.res_err    = res_err_q;
  assign state_dbg       = state_q;
  assign locked_dbg      = locked_q;
endmodule
